// File: rtl/kyber_acc_pkg.sv
`default_nettype none
// ============================================================================
// kyber_acc_pkg : command codes, sizes and reader state encoding shared by the
// accumulator and its load/read initiators.                     Rev 1.0
// ============================================================================
package kyber_acc_pkg;

   localparam logic [3:0] CMD_IDLE   = 4'd0;
   localparam logic [3:0] CMD_LOAD_A = 4'd1;
   localparam logic [3:0] CMD_LOAD_B = 4'd2;
   localparam logic [3:0] CMD_READ   = 4'd3;

   localparam int N_PAIRS = 128;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_ACK = 3'd1,
      ST_STREAM   = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_DONE     = 3'd4
   } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/pair_fifo.sv
`default_nettype none
// ============================================================================
// pair_fifo : synchronous FIFO holding captured {addr, a, b} pairs, with an
// occupancy count for the reader's credit logic.                Rev 1.0
// ============================================================================
module pair_fifo
#(
   parameter int WIDTH = 39,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);
   import kyber_acc_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign empty     = (count_q == '0);

   // The reader's credit rule must keep pushes within capacity.
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && (count_q == FULL_CNT)));
   a_no_underflow : assert property (@(posedge clk) disable iff (reset)
      !(pop && (count_q == '0)));

endmodule
`default_nettype wire

// File: rtl/accum_reader.sv
`default_nettype none
// ============================================================================
// accum_reader : read-side initiator; pulls 128 coefficient pairs from the
// accumulator and serialises them (a then b) on a valid/ready stream. Rev 1.0
// ============================================================================
module accum_reader
#(
   parameter int         DATA_W     = 16,
   parameter int         ADDR_W     = 7,
   parameter int         FIFO_DEPTH = 4,
   parameter int         RD_LAT     = 1,
   parameter logic [3:0] CMD_READ   = 4'd3,
   parameter int         TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [3:0]        acc_cmd,
   output logic              acc_readout,
   input  logic [3:0]        acc_status,
   input  logic [ADDR_W-1:0] acc_addr_out,
   input  logic [DATA_W-1:0] acc_data_a_out,
   input  logic [DATA_W-1:0] acc_data_b_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [7:0]        out_index,
   output logic              busy,
   output logic              done,
   output logic              err
);
   import kyber_acc_pkg::*;

   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int FIFO_W  = ADDR_W + 2 * DATA_W;
   localparam int TMR_W   = $clog2(TIMEOUT + 1);
   localparam int LAST_I  = N_PAIRS - 1;
   localparam int TMR_I   = TIMEOUT - 1;
   localparam logic [ADDR_W:0]   PAIRS_L   = N_PAIRS[ADDR_W:0];
   localparam logic [ADDR_W:0]   LAST_ISS  = LAST_I[ADDR_W:0];
   localparam logic [ADDR_W-1:0] LAST_PAIR = LAST_I[ADDR_W-1:0];
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_I[TMR_W-1:0];
   localparam logic [CNT_W:0]    CREDITS   = FIFO_DEPTH[CNT_W:0];

   rd_state_e         state_q, state_d;
   logic [ADDR_W:0]   issued_q, issued_d;
   logic [CNT_W-1:0]  in_flight_q, in_flight_d;
   logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
   logic [TMR_W-1:0]  wait_q, wait_d;
   logic              err_q, err_d;
   logic              half_q, half_d;
   logic [ADDR_W-1:0] out_pair_q, out_pair_d;
   logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

   logic              capture, accept, pop, last_word, start_ok;
   logic [FIFO_W-1:0] head_data;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic [ADDR_W-1:0] head_addr_unused;

   pair_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (capture),
      .push_data ({acc_addr_out, acc_data_a_out, acc_data_b_out}),
      .pop       (pop),
      .head_data (head_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   // Arrival order is authoritative; the stored address is kept only for debug.
   assign head_addr_unused = head_data[FIFO_W-1 -: ADDR_W];

   always_comb begin
      state_d     = state_q;
      issued_d    = issued_q;
      in_flight_d = in_flight_q;
      exp_addr_d  = exp_addr_q;
      wait_d      = wait_q;
      err_d       = err_q;
      half_d      = half_q;
      out_pair_d  = out_pair_q;
      rd_pipe_d   = rd_pipe_q << 1;
      acc_cmd     = CMD_IDLE;
      acc_readout = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      capture   = rd_pipe_q[RD_LAT-1];
      out_valid = !fifo_empty;
      out_data  = !out_valid ? '0 :
                  half_q     ? head_data[DATA_W-1:0] : head_data[2*DATA_W-1:DATA_W];
      out_index = out_valid ? 8'({out_pair_q, half_q}) : 8'd0;
      accept    = out_valid && out_ready;
      pop       = accept && half_q;
      last_word = pop && (out_pair_q == LAST_PAIR);
      start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

      case (state_q)
         ST_WAIT_ACK: begin
            acc_cmd = CMD_READ;
            busy    = 1'b1;
            if (acc_status == CMD_READ) begin
               state_d = ST_STREAM;
            end else if (wait_q == TMR_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_STREAM: begin
            acc_cmd     = CMD_READ;
            busy        = 1'b1;
            acc_readout = (issued_q < PAIRS_L) &&
                          (({1'b0, fifo_count} + {1'b0, in_flight_q}) < CREDITS);
            if (acc_readout && (issued_q == LAST_ISS)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            acc_cmd = CMD_READ;
            busy    = 1'b1;
            if (last_word && (in_flight_q == '0)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      rd_pipe_d[0] = acc_readout;
      if (acc_readout) begin
         issued_d = issued_q + 1'b1;
      end
      case ({acc_readout, capture})
         2'b10:   in_flight_d = in_flight_q + 1'b1;
         2'b01:   in_flight_d = in_flight_q - 1'b1;
         default: in_flight_d = in_flight_q;
      endcase

      if (capture) begin
         exp_addr_d = exp_addr_q + 1'b1;
         if (acc_addr_out != exp_addr_q) begin
            err_d = 1'b1;
         end
      end
      if (((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && (acc_status != CMD_READ)) begin
         err_d = 1'b1;
      end

      if (accept) begin
         half_d = !half_q;
         if (half_q) begin
            out_pair_d = out_pair_q + 1'b1;
         end
      end

      // DONE behaves like IDLE for a back-to-back start.
      if (start_ok) begin
         state_d    = ST_WAIT_ACK;
         err_d      = 1'b0;
         issued_d   = '0;
         exp_addr_d = '0;
         wait_d     = '0;
         half_d     = 1'b0;
         out_pair_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         issued_q    <= '0;
         in_flight_q <= '0;
         exp_addr_q  <= '0;
         wait_q      <= '0;
         err_q       <= 1'b0;
         half_q      <= 1'b0;
         out_pair_q  <= '0;
         rd_pipe_q   <= '0;
      end else begin
         state_q     <= state_d;
         issued_q    <= issued_d;
         in_flight_q <= in_flight_d;
         exp_addr_q  <= exp_addr_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         half_q      <= half_d;
         out_pair_q  <= out_pair_d;
         rd_pipe_q   <= rd_pipe_d;
      end
   end

   assign err = err_q;

endmodule
`default_nettype wire
